time_entry_accumulator: RTL
===========================

# time_entry_accumulator

Builds the countdown start value from operator keypad digits and hands it to the countdown timer as a packed 4-digit BCD word (MM:SS) with a commit flag. It sits between the keypad/button front end and the timer. It drives `time_count` and `accum_done`, which the timer samples together with `begin_timer`. Entry is microwave-style: each digit shifts in from the right, and a commit step validates the seconds-tens digit.

## Interface
Parameters:
- `MAX_SEC_TEN`, default 5: largest legal seconds-tens digit at commit.
- `ALLOW_ZERO`, default 1: if 0, committing 00:00 is rejected.

Ports:
- `clock` input 1: sole clock; all logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `digit_valid` input 1: one-cycle strobe; `digit` is valid this cycle.
- `digit` input 4: BCD digit value; 10–15 are illegal.
- `backspace` input 1: one-cycle strobe; remove the last digit.
- `clear` input 1: one-cycle strobe; discard the entry.
- `enter` input 1: one-cycle strobe; validate and commit.
- `time_count` output 16: {min_ten, min_one, sec_ten, sec_one} edit/commit buffer.
- `accum_done` output 1: level; high while the committed value is held.
- `digit_count` output 3: number of digits entered, 0–4.
- `entry_error` output 1: one-cycle pulse on any rejected action.

## Operation
- States: EMPTY, ENTRY, DONE.
- Reset values: state EMPTY, `time_count`=16'h0000, `digit_count`=0, `accum_done`=0, `entry_error`=0.
- Action priority per cycle: `clear` > `enter` > `backspace` > `digit_valid`. Only the highest-priority asserted action takes effect; the others are dropped silently with no error.
- `clear`, any state:
  - `time_count`=0, `digit_count`=0, `accum_done`=0, go to EMPTY.
- `digit_valid`, digit ≤ 9:
  - EMPTY: `time_count`={12'h000, digit}, count=1, go to ENTRY.
  - ENTRY with count<4: `time_count`={time_count[11:0], digit}, count+1.
  - ENTRY with count=4: no change, `entry_error` pulses.
  - DONE: start a fresh entry as from EMPTY, `accum_done` falls, go to ENTRY.
- `digit_valid` with digit > 9, any state: no change, `entry_error` pulses.
- `backspace`:
  - ENTRY: `time_count`={4'h0, time_count[15:4]}, count−1. If the count becomes 0, go to EMPTY.
  - EMPTY: no change, `entry_error` pulses.
  - DONE: return to ENTRY with the buffer unchanged, `accum_done` falls, no shift.
- `enter`:
  - In EMPTY or ENTRY, the buffer is legal when time_count[7:4] ≤ MAX_SEC_TEN, and also (ALLOW_ZERO or time_count≠0).
  - Legal: go to DONE, `accum_done`=1.
  - Illegal: state unchanged, `entry_error` pulses.
  - In DONE: no change, no error.
- Only the low `digit_count` digits are meaningful; higher nibbles always read 0.
- `time_count` is stable for every cycle that `accum_done` is high.

## Timing
- All outputs are registered. An action strobed in cycle N is visible after the clock edge ending cycle N (1-cycle latency).
- `entry_error` is high for exactly the cycle after the rejected action; back-to-back errors give back-to-back pulses.
- `accum_done` rises in the same cycle that `time_count` holds the committed value. It falls on the edge that accepts a digit, backspace or clear.
- Strobes are assumed single-cycle and synchronous. A held strobe is treated as a repeat action each cycle; no edge detection is done here.
- `reset_n` asserted mid-entry clears all outputs immediately (asynchronously). Release is synchronous to `clock`, with no action accepted in the release cycle.

## Structure
- A shared package holds:
  - state enum (EMPTY, ENTRY, DONE);
  - `NUM_DIGITS`=4 and `BCD_MAX`=9;
  - the BCD time-word field offsets (min_ten [15:12], min_one [11:8], sec_ten [7:4], sec_one [3:0]), shared with the countdown timer.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset, then digits 1,3,0 then `enter` → `time_count`=16'h0130, `digit_count`=3, `accum_done`=1 one cycle after `enter`, no error.
- Digits 1,2,3,4,5 → `time_count`=16'h1234 after the fourth digit; the fifth digit pulses `entry_error` and leaves the buffer unchanged.
- Digits 1,7,0 then `enter` (sec_ten=7) → `entry_error` pulse, `accum_done` stays 0, state ENTRY. Then `backspace`,`backspace` → 16'h0001, count 1.
- Commit 16'h0045, then digit 2 → `accum_done` falls, `time_count`=16'h0002, count 1. Then `clear` and `enter` in the same cycle → clear wins: 0, EMPTY, no error.
- Digit 4'hA in EMPTY → `entry_error` pulse, no state change. With ALLOW_ZERO=0, digit 0 then `enter` → `entry_error`, no commit.
- Assert `reset_n` low mid-entry at 16'h0012 → all outputs 0 immediately; after release, digit 5 → 16'h0005.

Source files
------------

// File: rtl/time_entry_accumulator_pkg.sv
// time_entry_accumulator_pkg: shared entry states, BCD limits and MM:SS word layout
package time_entry_accumulator_pkg;
    typedef enum logic [1:0] {EMPTY, ENTRY, DONE} state_t;
    localparam logic [2:0] NUM_DIGITS = 3'd4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int MIN_TEN_LSB = 12;
    localparam int MIN_ONE_LSB = 8;
    localparam int SEC_TEN_LSB = 4;
    localparam int SEC_ONE_LSB = 0;
    function automatic logic [3:0] sec_ten(input logic [15:0] w);
        return w[SEC_TEN_LSB +: 4];
    endfunction
    function automatic logic [15:0] shift_in(input logic [15:0] w, input logic [3:0] d);
        return {w[MIN_ONE_LSB +: 4], w[SEC_TEN_LSB +: 4], w[SEC_ONE_LSB +: 4], d};
    endfunction
    function automatic logic [15:0] shift_out(input logic [15:0] w);
        return {4'h0, w[MIN_TEN_LSB +: 4], w[MIN_ONE_LSB +: 4], w[SEC_TEN_LSB +: 4]};
    endfunction
endpackage

// File: rtl/time_entry_accumulator.sv
// time_entry_accumulator: keypad digit entry to committed MM:SS BCD countdown start value
// Ports: clock/reset_n (async active-low); digit_valid+digit, backspace, clear, enter strobes in;
// time_count (MM:SS BCD), accum_done (commit held), digit_count (0-4), entry_error (reject pulse) out.
module time_entry_accumulator
    import time_entry_accumulator_pkg::*;
#(
    parameter int MAX_SEC_TEN = 5,
    parameter bit ALLOW_ZERO  = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        backspace,
    input  logic        clear,
    input  logic        enter,
    output logic [15:0] time_count,
    output logic        accum_done,
    output logic [2:0]  digit_count,
    output logic        entry_error
);
    state_t      state, state_next;
    logic [15:0] time_next;
    logic [2:0]  count_next;
    logic        error_next;
    logic        digit_ok, legal;

    assign digit_ok = digit <= BCD_MAX;
    assign legal    = (sec_ten(time_count) <= 4'(MAX_SEC_TEN)) && (ALLOW_ZERO || time_count != 16'h0000);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            time_count  <= 16'h0000;
            digit_count <= 3'd0;
            accum_done  <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            state       <= state_next;
            time_count  <= time_next;
            digit_count <= count_next;
            accum_done  <= state_next == DONE;
            entry_error <= error_next;
        end
    end

    // A commit of 00:00 from EMPTY leaves DONE holding zero digits, so
    // backspace out of DONE lands in EMPTY when there is nothing to edit.
    always_comb begin
        state_next = state;
        if (clear)
            state_next = EMPTY;
        else if (enter)
            state_next = (state != DONE && legal) ? DONE : state;
        else if (backspace)
            state_next = (state == EMPTY) ? EMPTY
                       : (state == DONE) ? (digit_count == 3'd0 ? EMPTY : ENTRY)
                       : (digit_count == 3'd1 ? EMPTY : ENTRY);
        else if (digit_valid && digit_ok)
            state_next = ENTRY;
    end

    always_comb begin
        time_next  = time_count;
        count_next = digit_count;
        error_next = 1'b0;
        if (clear) begin
            time_next  = 16'h0000;
            count_next = 3'd0;
        end else if (enter) begin
            error_next = state != DONE && !legal;
        end else if (backspace) begin
            time_next  = (state == ENTRY) ? shift_out(time_count) : time_count;
            count_next = (state == ENTRY) ? digit_count - 3'd1 : digit_count;
            error_next = state == EMPTY;
        end else if (digit_valid) begin
            if (!digit_ok)
                error_next = 1'b1;
            else if (state != ENTRY) begin
                time_next  = {12'h000, digit};
                count_next = 3'd1;
            end else if (digit_count == NUM_DIGITS)
                error_next = 1'b1;
            else begin
                time_next  = shift_in(time_count, digit);
                count_next = digit_count + 3'd1;
            end
        end
    end
endmodule
